// File: rtl/div_arbiter.sv
// div_arbiter: two-port scheduler for a shared iterative unsigned divider with RISC-V signed/special-case handling.
module div_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  input  logic            req1_valid_i,
  output logic            req0_ready_o,
  output logic            req1_ready_o,
  input  logic [1:0]      req0_op_i,
  input  logic [1:0]      req1_op_i,
  input  logic [XLEN-1:0] req0_opr1_i,
  input  logic [XLEN-1:0] req1_opr1_i,
  input  logic [XLEN-1:0] req0_opr2_i,
  input  logic [XLEN-1:0] req1_opr2_i,
  input  logic            flush0_i,
  input  logic            flush1_i,
  output logic            rsp0_valid_o,
  output logic            rsp1_valid_o,
  input  logic            rsp0_ready_i,
  input  logic            rsp1_ready_i,
  output logic [XLEN-1:0] rsp0_result_o,
  output logic [XLEN-1:0] rsp1_result_o,
  output logic            dvd_start_o,
  output logic [XLEN-1:0] dvd_opr1_o,
  output logic [XLEN-1:0] dvd_opr2_o,
  input  logic            dvd_done_i,
  input  logic [XLEN-1:0] dvd_quo_i,
  input  logic [XLEN-1:0] dvd_rem_i,
  output logic            busy_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t state_q, state_d;
  logic owner_q, owner_d, rr_q, rr_d, sign1_q, sign1_d, sign2_q, sign2_d;
  logic [1:0] op_q, op_d;
  logic [XLEN-1:0] mag1_q, mag1_d, mag2_q, mag2_d, result_q, result_d;
  logic start_q, busy_q, rsp0_valid_q, rsp1_valid_q;
  logic v0, v1, acc, sel, s1, s2, dz, ovf, own_flush, own_rdy;
  logic [1:0] op;
  logic [XLEN-1:0] a, b, spec_res, core_res;
  // A flushing port is treated as not requesting, so the other port may win.
  assign v0 = req0_valid_i & ~flush0_i;
  assign v1 = req1_valid_i & ~flush1_i;
  assign req0_ready_o = ~rst & (state_q == IDLE) & v0 & (~v1 | ~rr_q);
  assign req1_ready_o = ~rst & (state_q == IDLE) & v1 & (~v0 | rr_q);
  assign acc = req0_ready_o | req1_ready_o;
  assign sel = req1_ready_o;
  assign op = sel ? req1_op_i : req0_op_i;
  assign a = sel ? req1_opr1_i : req0_opr1_i;
  assign b = sel ? req1_opr2_i : req0_opr2_i;
  assign s1 = ~op[0] & a[XLEN-1];
  assign s2 = ~op[0] & b[XLEN-1];
  assign dz = (b == '0);
  assign ovf = ~op[0] & (a == MIN_NEG) & (&b);
  assign spec_res = dz ? (op[1] ? a : '1) : (op[1] ? '0 : MIN_NEG);
  assign core_res = op_q[1] ? (sign1_q ? -dvd_rem_i : dvd_rem_i)
                            : ((sign1_q ^ sign2_q) ? -dvd_quo_i : dvd_quo_i);
  assign own_flush = owner_q ? flush1_i : flush0_i;
  assign own_rdy = owner_q ? rsp1_ready_i : rsp0_ready_i;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    op_d = op_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    mag1_d = mag1_q;
    mag2_d = mag2_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (acc) begin
        owner_d = sel;
        rr_d = ~sel;
        op_d = op;
        sign1_d = s1;
        sign2_d = s2;
        mag1_d = s1 ? -a : a;
        mag2_d = s2 ? -b : b;
        result_d = spec_res;
        state_d = (dz | ovf) ? RESP : ISSUE;
      end
      ISSUE: state_d = own_flush ? DRAIN : WAIT;
      WAIT: begin
        result_d = dvd_done_i ? core_res : result_q;
        state_d = dvd_done_i ? (own_flush ? IDLE : RESP) : (own_flush ? DRAIN : WAIT);
      end
      RESP: state_d = (own_flush | own_rdy) ? IDLE : RESP;
      DRAIN: state_d = dvd_done_i ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q <= 1'b0;
      op_q <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      mag1_q <= '0;
      mag2_q <= '0;
      result_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      op_q <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      mag1_q <= mag1_d;
      mag2_q <= mag2_d;
      result_q <= result_d;
      start_q <= (state_d == ISSUE);
      busy_q <= (state_d != IDLE);
      rsp0_valid_q <= (state_d == RESP) & ~owner_d;
      rsp1_valid_q <= (state_d == RESP) & owner_d;
    end
  end
  assign dvd_start_o = start_q;
  assign busy_o = busy_q;
  assign dvd_opr1_o = mag1_q;
  assign dvd_opr2_o = mag2_q;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp0_result_o = rsp0_valid_q ? result_q : '0;
  assign rsp1_result_o = rsp1_valid_q ? result_q : '0;
endmodule
